// File: rtl/fir_hist_pkg.sv
// Shared constants, register map and FSM encodings for fir_hist_ctrl.
// Optional feature macro used by the design: HIST_DOUBLE_BUF_EN.
package fir_hist_pkg;

    localparam int DEF_COEF_NUM  = 25;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_HIST_BINS = 256;
    localparam int DEF_BIN_W     = 16;
    localparam int DEF_ADDR_W    = 10;

    localparam int ADDR_CTRL      = 32'h000;
    localparam int ADDR_STATUS    = 32'h001;
    localparam int ADDR_COEF_BASE = 32'h040;
    localparam int ADDR_BIN_BASE  = 32'h100;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ARM_BIT    = 1;

    localparam int STAT_LOAD_BUSY  = 0;
    localparam int STAT_COMMIT_PND = 1;
    localparam int STAT_HIST_VALID = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_WR_ERR     = 4;
    localparam int STAT_FRONT_BANK = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        LOAD    = 2'd2
    } coef_state_e;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        SAMPLE = 2'd1,
        ACK    = 2'd2
    } hist_state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin buffer: one write port, one synchronous read port
// with a single cycle of read latency. Contents are not reset.
module hist_bin_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fir_hist_ctrl.sv
// Register-bus controller for FIR coefficient commits and histogram drain.
// Define HIST_DOUBLE_BUF_EN to make the bin buffer a ping-pong pair.
module fir_hist_ctrl
    import fir_hist_pkg::*;
#(
    parameter int COEF_NUM  = DEF_COEF_NUM,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int HIST_BINS = DEF_HIST_BINS,
    parameter int BIN_W     = DEF_BIN_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs_i,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_rvalid,
    output logic              fir_coef_write,
    output logic [COEF_W-1:0] fir_coef_data,
    input  logic [BIN_W-1:0]  hist_bin_data,
    input  logic              hist_bin_ready,
    output logic              hist_bin_saved,
    output logic              irq
);

    localparam int CIDX_W = $clog2(COEF_NUM);
    localparam int BIDX_W = $clog2(HIST_BINS);
`ifdef HIST_DOUBLE_BUF_EN
    localparam int RAM_DEPTH = 2 * HIST_BINS;
`else
    localparam int RAM_DEPTH = HIST_BINS;
`endif
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [ADDR_W-1:0] CTRL_A      = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] STATUS_A    = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] COEF_BASE_A = ADDR_W'(ADDR_COEF_BASE);
    localparam logic [ADDR_W-1:0] BIN_BASE_A  = ADDR_W'(ADDR_BIN_BASE);
    localparam logic [ADDR_W-1:0] COEF_NUM_A  = ADDR_W'(COEF_NUM);
    localparam logic [ADDR_W-1:0] BINS_A      = ADDR_W'(HIST_BINS);
    localparam logic [CIDX_W-1:0] LAST_COEF   = CIDX_W'(COEF_NUM - 1);
    localparam logic [BIDX_W-1:0] LAST_BIN    = BIDX_W'(HIST_BINS - 1);

    // Address decode
    logic [ADDR_W-1:0] coef_rel_s, bin_rel_s;
    logic [CIDX_W-1:0] coef_off_s;
    logic [BIDX_W-1:0] bin_off_s;
    logic              coef_hit_s, bin_hit_s, status_wr_s, commit_s, arm_s, vs_rise_s;
    logic              unused_ok_s;

    assign coef_rel_s  = reg_addr - COEF_BASE_A;
    assign bin_rel_s   = reg_addr - BIN_BASE_A;
    assign coef_off_s  = coef_rel_s[CIDX_W-1:0];
    assign bin_off_s   = bin_rel_s[BIDX_W-1:0];
    assign coef_hit_s  = (coef_rel_s < COEF_NUM_A);
    assign bin_hit_s   = (bin_rel_s < BINS_A);
    assign status_wr_s = reg_wr && (reg_addr == STATUS_A);
    assign commit_s    = reg_wr && (reg_addr == CTRL_A) && reg_wdata[CTRL_COMMIT_BIT];
    assign arm_s       = reg_wr && (reg_addr == CTRL_A) && reg_wdata[CTRL_ARM_BIT];
    assign unused_ok_s = ^reg_wdata[31:COEF_W];

    // Coefficient path state
    coef_state_e       coef_state_q, coef_state_d;
    logic [CIDX_W-1:0] load_idx_q, load_idx_d;
    logic [COEF_W-1:0] shadow_q [COEF_NUM];
    logic [COEF_W-1:0] shadow_d [COEF_NUM];
    logic              vs_prev_q;
    logic              commit_pending_q, commit_pending_d;
    logic              wr_err_q, wr_err_d;
    logic              coef_write_q, coef_write_d;
    logic [COEF_W-1:0] coef_data_q, coef_data_d;

    // Histogram path state
    hist_state_e       hist_state_q, hist_state_d;
    logic [BIDX_W-1:0] bin_idx_q, bin_idx_d;
    logic              armed_q, armed_d;
    logic              hist_valid_q, hist_valid_d;
    logic              overrun_q, overrun_d;
    logic              saved_q, saved_d;
    logic              irq_q, irq_d;
    logic              front_q, front_d;

    // Read path state
    logic              rvalid_q, rvalid_d;
    logic              rd_bin_q, rd_bin_d;
    logic [31:0]       csr_rdata_q, csr_rdata_d;

    logic              ram_we_s;
    logic [RAM_AW-1:0] ram_waddr_s, ram_raddr_s;
    logic [BIN_W-1:0]  ram_rdata_s;

    assign vs_rise_s = vs_i && !vs_prev_q;

    // Shadow registers and the vertical-blank coefficient streamer
    always_comb begin
        coef_state_d     = coef_state_q;
        load_idx_d       = load_idx_q;
        commit_pending_d = commit_pending_q;
        coef_write_d     = 1'b0;
        coef_data_d      = {COEF_W{1'b0}};
        shadow_d         = shadow_q;

        if (status_wr_s && reg_wdata[STAT_WR_ERR]) begin
            wr_err_d = 1'b0;
        end else begin
            wr_err_d = wr_err_q;
        end

        // Loading reads shadow_q live, so a write now would tear the set.
        if (reg_wr && coef_hit_s) begin
            if (coef_state_q == LOAD) begin
                wr_err_d = 1'b1;
            end else begin
                shadow_d[coef_off_s] = reg_wdata[COEF_W-1:0];
            end
        end else begin
            shadow_d = shadow_q;
        end

        case (coef_state_q)
            IDLE: begin
                if (commit_s) begin
                    coef_state_d     = WAIT_VS;
                    commit_pending_d = 1'b1;
                    load_idx_d       = {CIDX_W{1'b0}};
                end else begin
                    coef_state_d = IDLE;
                end
            end
            WAIT_VS: begin
                if (vs_rise_s) begin
                    coef_state_d = LOAD;
                    load_idx_d   = {CIDX_W{1'b0}};
                end else begin
                    coef_state_d = WAIT_VS;
                end
            end
            LOAD: begin
                coef_write_d = 1'b1;
                coef_data_d  = shadow_q[load_idx_q];
                if (load_idx_q == LAST_COEF) begin
                    coef_state_d     = IDLE;
                    commit_pending_d = 1'b0;
                    load_idx_d       = {CIDX_W{1'b0}};
                end else begin
                    load_idx_d = load_idx_q + CIDX_W'(1);
                end
            end
            default: begin
                coef_state_d = IDLE;
            end
        endcase
    end

    // Histogram drain: every ready bin is acknowledged, captured only when armed
    always_comb begin
        hist_state_d = hist_state_q;
        bin_idx_d    = bin_idx_q;
        armed_d      = armed_q;
        hist_valid_d = hist_valid_q;
        irq_d        = 1'b0;
        front_d      = front_q;
        ram_we_s     = 1'b0;

        if (status_wr_s && reg_wdata[STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (arm_s) begin
            armed_d      = 1'b1;
            hist_valid_d = 1'b0;
            bin_idx_d    = {BIDX_W{1'b0}};
            hist_state_d = SAMPLE;
        end else begin
            case (hist_state_q)
                H_IDLE: begin
                    if (hist_bin_ready) begin
                        hist_state_d = ACK;
                        overrun_d    = 1'b1;
                    end else begin
                        hist_state_d = H_IDLE;
                    end
                end
                SAMPLE: begin
                    if (hist_bin_ready) begin
                        ram_we_s     = 1'b1;
                        hist_state_d = ACK;
                    end else begin
                        hist_state_d = SAMPLE;
                    end
                end
                ACK: begin
                    if (!armed_q) begin
                        hist_state_d = H_IDLE;
                    end else if (bin_idx_q == LAST_BIN) begin
                        hist_state_d = H_IDLE;
                        hist_valid_d = 1'b1;
                        armed_d      = 1'b0;
                        irq_d        = 1'b1;
                        bin_idx_d    = {BIDX_W{1'b0}};
                        front_d      = !front_q;
                    end else begin
                        hist_state_d = SAMPLE;
                        bin_idx_d    = bin_idx_q + BIDX_W'(1);
                    end
                end
                default: begin
                    hist_state_d = H_IDLE;
                end
            endcase
        end

        saved_d = (hist_state_d == ACK);
    end

`ifdef HIST_DOUBLE_BUF_EN
    assign ram_waddr_s = {!front_q, bin_idx_q};
    assign ram_raddr_s = {front_q, bin_off_s};
`else
    assign ram_waddr_s = bin_idx_q;
    assign ram_raddr_s = bin_off_s;
`endif

    // Register read mux; bin reads take their data straight from the RAM output register
    always_comb begin
        rvalid_d    = reg_rd;
        rd_bin_d    = 1'b0;
        csr_rdata_d = 32'd0;
        if (reg_rd) begin
            if (reg_addr == STATUS_A) begin
                csr_rdata_d[STAT_LOAD_BUSY]  = (coef_state_q == LOAD);
                csr_rdata_d[STAT_COMMIT_PND] = commit_pending_q;
                csr_rdata_d[STAT_HIST_VALID] = hist_valid_q;
                csr_rdata_d[STAT_OVERRUN]    = overrun_q;
                csr_rdata_d[STAT_WR_ERR]     = wr_err_q;
`ifdef HIST_DOUBLE_BUF_EN
                csr_rdata_d[STAT_FRONT_BANK] = front_q;
`else
                csr_rdata_d[STAT_FRONT_BANK] = 1'b0;
`endif
            end else if (coef_hit_s) begin
                csr_rdata_d = {{(32-COEF_W){1'b0}}, shadow_q[coef_off_s]};
            end else if (bin_hit_s) begin
                rd_bin_d = 1'b1;
            end else begin
                csr_rdata_d = 32'd0;
            end
        end else begin
            csr_rdata_d = 32'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_state_q     <= IDLE;
            load_idx_q       <= {CIDX_W{1'b0}};
            vs_prev_q        <= 1'b0;
            commit_pending_q <= 1'b0;
            wr_err_q         <= 1'b0;
            coef_write_q     <= 1'b0;
            coef_data_q      <= {COEF_W{1'b0}};
            for (int i = 0; i < COEF_NUM; i++) begin
                shadow_q[i] <= {COEF_W{1'b0}};
            end
            hist_state_q     <= H_IDLE;
            bin_idx_q        <= {BIDX_W{1'b0}};
            armed_q          <= 1'b0;
            hist_valid_q     <= 1'b0;
            overrun_q        <= 1'b0;
            saved_q          <= 1'b0;
            irq_q            <= 1'b0;
            front_q          <= 1'b0;
            rvalid_q         <= 1'b0;
            rd_bin_q         <= 1'b0;
            csr_rdata_q      <= 32'd0;
        end else begin
            coef_state_q     <= coef_state_d;
            load_idx_q       <= load_idx_d;
            vs_prev_q        <= vs_i;
            commit_pending_q <= commit_pending_d;
            wr_err_q         <= wr_err_d;
            coef_write_q     <= coef_write_d;
            coef_data_q      <= coef_data_d;
            shadow_q         <= shadow_d;
            hist_state_q     <= hist_state_d;
            bin_idx_q        <= bin_idx_d;
            armed_q          <= armed_d;
            hist_valid_q     <= hist_valid_d;
            overrun_q        <= overrun_d;
            saved_q          <= saved_d;
            irq_q            <= irq_d;
            front_q          <= front_d;
            rvalid_q         <= rvalid_d;
            rd_bin_q         <= rd_bin_d;
            csr_rdata_q      <= csr_rdata_d;
        end
    end

    hist_bin_ram #(
        .DEPTH (RAM_DEPTH),
        .W     (BIN_W),
        .AW    (RAM_AW)
    ) u_bin_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (hist_bin_data),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    assign reg_rdata      = rd_bin_q ? {{(32-BIN_W){1'b0}}, ram_rdata_s} : csr_rdata_q;
    assign reg_rvalid     = rvalid_q;
    assign fir_coef_write = coef_write_q;
    assign fir_coef_data  = coef_data_q;
    assign hist_bin_saved = saved_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_fir_hist_ctrl.sv
// Randomized self-checking bench for fir_hist_ctrl against a behavioural model.
// Honours HIST_DOUBLE_BUF_EN to pick the expected bin-buffer read behaviour.
module tb_fir_hist_ctrl;

    logic        clk = 1'b0;
    logic        rst, vs_i, reg_wr, reg_rd;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_rvalid, fir_coef_write;
    logic [15:0] fir_coef_data, hist_bin_data;
    logic        hist_bin_ready, hist_bin_saved, irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [15:0] shadow_m [25];
    logic [15:0] shown_m  [256];
    logic [15:0] frame_m  [256];
    logic [15:0] got      [32];
    bit hist_valid_m = 1'b0, overrun_m = 1'b0, wr_err_m = 1'b0, front_m = 1'b0;

    always #5 clk = ~clk;

    fir_hist_ctrl dut (
        .clk(clk), .rst(rst), .vs_i(vs_i),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .fir_coef_write(fir_coef_write), .fir_coef_data(fir_coef_data),
        .hist_bin_data(hist_bin_data), .hist_bin_ready(hist_bin_ready),
        .hist_bin_saved(hist_bin_saved), .irq(irq)
    );

    function automatic logic [31:0] status_m(input bit busy, input bit pend);
        logic [31:0] s;
        s = 32'd0;
        s[0] = busy;
        s[1] = pend;
        s[2] = hist_valid_m;
        s[3] = overrun_m;
        s[4] = wr_err_m;
`ifdef HIST_DOUBLE_BUF_EN
        s[5] = front_m;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [9:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [9:0] a, output logic [31:0] d, output logic v);
        reg_rd = 1'b1; reg_addr = a;
        tick();
        v = reg_rvalid; d = reg_rdata;
        reg_rd = 1'b0;
    endtask

    // Raises vs_i and collects the coefficient burst; optionally writes 0x045 mid-burst.
    task automatic run_load(input int inj_pos, input logic [15:0] inj_data,
                            output int lat, output int cnt);
        lat = 0; cnt = 0;
        vs_i = 1'b1;
        while (lat < 10 && !fir_coef_write) begin
            tick();
            lat++;
            vs_i = 1'b0;
        end
        while (fir_coef_write && cnt < 30) begin
            got[cnt] = fir_coef_data;
            reg_wr = (cnt == inj_pos);
            reg_addr = 10'h045; reg_wdata = {16'd0, inj_data};
            cnt++;
            tick();
        end
        reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({reg_rvalid, fir_coef_write, hist_bin_saved, irq} !== 4'b0000 || reg_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rvalid/wr/saved/irq=%b rdata=%h, want 0000 / 0",
                     {reg_rvalid, fir_coef_write, hist_bin_saved, irq}, reg_rdata);
        end
        reg_read(10'h001, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'd0}) begin
            n_errors++; $display("FAIL reset_status: got v=%b d=%h, want 1 / 0", v, d);
        end
        reg_read(10'(64 + $urandom_range(0, 24)), d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'd0}) begin
            n_errors++; $display("FAIL reset_shadow: got v=%b d=%h, want 1 / 0", v, d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d; logic v; int k;
        for (int i = 0; i < 25; i++) begin
            shadow_m[i] = 16'($urandom);
            reg_write(10'(64 + i), {16'($urandom), shadow_m[i]});
        end
        for (int n = 0; n < 5; n++) begin
            k = $urandom_range(0, 24);
            reg_read(10'(64 + k), d, v);
            n_checks++;
            if ({v, d} !== {1'b1, 16'd0, shadow_m[k]}) begin
                n_errors++;
                $display("FAIL shadow_readback[%0d]: got %h, want %h", k, d, shadow_m[k]);
            end
        end
        reg_write(10'h300, $urandom);
        reg_read(10'h300, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 32'd0}) begin
            n_errors++; $display("FAIL unmapped_read: got v=%b d=%h, want 1 / 0", v, d);
        end
        reg_read(10'h000, d, v);
        tick();
        n_checks++;
        if ({v, d, reg_rvalid} !== {1'b1, 32'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL ctrl_read_pulse: got v=%b d=%h next_rvalid=%b, want 1 / 0 / 0", v, d, reg_rvalid);
        end
    endtask

    task automatic test_commit_load();
        logic [31:0] d; logic v; int lat, cnt;
        for (int i = 0; i < 25; i++) begin
            shadow_m[i] = 16'(16'h100 + i);
            reg_write(10'(64 + i), {16'd0, shadow_m[i]});
        end
        reg_write(10'h000, 32'h1);
        repeat (40) tick();
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b1)) begin
            n_errors++; $display("FAIL pending_status: got %h, want %h", d, status_m(1'b0, 1'b1));
        end
        run_load(-1, 16'd0, lat, cnt);
        n_checks++;
        if (lat !== 2 || cnt !== 25) begin
            n_errors++; $display("FAIL load_shape: latency=%0d count=%0d, want 2 and 25", lat, cnt);
        end
        for (int i = 0; i < 25 && i < cnt; i++) begin
            n_checks++;
            if (got[i] !== shadow_m[i]) begin
                n_errors++; $display("FAIL load_value[%0d]: got %h, want %h", i, got[i], shadow_m[i]);
            end
        end
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL post_load_status: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
    endtask

    task automatic test_shadow_update();
        logic [31:0] d; logic v; int lat, cnt;
        for (int i = 0; i < 25; i++) begin
            shadow_m[i] = 16'($urandom);
            reg_write(10'(64 + i), {16'd0, shadow_m[i]});
        end
        reg_write(10'h000, 32'h1);
        repeat ($urandom_range(3, 20)) tick();
        reg_write(10'h043, 32'h1234);
        shadow_m[3] = 16'h1234;
        reg_write(10'h000, 32'h1);
        run_load(5, 16'($urandom), lat, cnt);
        wr_err_m = 1'b1;
        n_checks++;
        if (cnt !== 25) begin
            n_errors++; $display("FAIL upd_load_count: got %0d, want 25", cnt);
        end
        for (int i = 0; i < 25 && i < cnt; i++) begin
            n_checks++;
            if (got[i] !== shadow_m[i]) begin
                n_errors++; $display("FAIL upd_load_value[%0d]: got %h, want %h", i, got[i], shadow_m[i]);
            end
        end
        reg_read(10'h045, d, v);
        n_checks++;
        if (d !== {16'd0, shadow_m[5]}) begin
            n_errors++; $display("FAIL dropped_write: got %h, want %h", d, shadow_m[5]);
        end
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL wr_err_status: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
        reg_write(10'h001, 32'h10);
        wr_err_m = 1'b0;
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL wr_err_clear: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d; logic v; int seen = 0; int guard = 0;
        reg_write(10'h000, 32'h1);
        repeat (4) tick();
        vs_i = 1'b1;
        while (seen < 10 && guard < 40) begin
            tick();
            vs_i = 1'b0;
            guard++;
            if (fir_coef_write) seen++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (seen !== 10 || fir_coef_write !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_load: writes_seen=%0d wr=%b, want 10 / 0", seen, fir_coef_write);
        end
        for (int i = 0; i < 25; i++) shadow_m[i] = 16'd0;
        hist_valid_m = 1'b0; overrun_m = 1'b0; wr_err_m = 1'b0; front_m = 1'b0;
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++; $display("FAIL reset_mid_status: got %h, want 0", d);
        end
        tick();
        n_checks++;
        if (fir_coef_write !== 1'b0) begin
            n_errors++; $display("FAIL reset_no_resume: got wr=%b, want 0", fir_coef_write);
        end
    endtask

    // ARMs and drains frame_m; optionally reads the bin buffer mid-capture.
    task automatic hist_capture(input bit mid_reads);
        logic [31:0] d; logic v; int pidx = 0, cyc = 0, last = -1, gaps = 0, irqs = 0, after = 0;
        int rd_state = 0, rb; logic [15:0] want;
        int rlo = $urandom_range(0, 49);
        int rhi = $urandom_range(200, 255);
        reg_write(10'h000, 32'h2);
        hist_valid_m = 1'b0;
        while (cyc < 2000 && after < 3) begin
            hist_bin_ready = (pidx < 256);
            hist_bin_data  = (pidx < 256) ? frame_m[pidx] : 16'd0;
            if (mid_reads && ((pidx == 100 && rd_state == 0) || (pidx == 120 && rd_state == 2))) begin
                rb = (rd_state == 0) ? rlo : rhi;
                reg_rd = 1'b1; reg_addr = 10'(256 + rb);
                rd_state++;
            end
            tick();
            cyc++;
            if (reg_rd) begin
                reg_rd = 1'b0;
`ifdef HIST_DOUBLE_BUF_EN
                want = shown_m[rb];
`else
                want = (rb < pidx) ? frame_m[rb] : shown_m[rb];
`endif
                n_checks++;
                if ({reg_rvalid, reg_rdata} !== {1'b1, 16'd0, want}) begin
                    n_errors++; $display("FAIL mid_capture_read[%0d]: got %h, want %h", rb, reg_rdata, want);
                end
                rd_state++;
            end
            if (hist_bin_saved) begin
                if (last >= 0 && cyc - last != 2) gaps++;
                last = cyc;
                pidx++;
            end
            if (irq) irqs++;
            if (pidx == 256) after++;
        end
        hist_bin_ready = 1'b0;
        n_checks++;
        if (pidx !== 256 || gaps !== 0 || irqs !== 1) begin
            n_errors++; $display("FAIL capture_handshake: saved=%0d gaps=%0d irqs=%0d, want 256 0 1", pidx, gaps, irqs);
        end
        for (int i = 0; i < 256; i++) shown_m[i] = frame_m[i];
        hist_valid_m = 1'b1;
        front_m = !front_m;
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL capture_status: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
        reg_read(10'h1FF, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 16'd0, shown_m[255]}) begin
            n_errors++; $display("FAIL bin_255: got %h, want %h", d, shown_m[255]);
        end
        for (int n = 0; n < 4; n++) begin
            rb = $urandom_range(0, 255);
            reg_read(10'(256 + rb), d, v);
            n_checks++;
            if ({v, d} !== {1'b1, 16'd0, shown_m[rb]}) begin
                n_errors++; $display("FAIL bin_read[%0d]: got %h, want %h", rb, d, shown_m[rb]);
            end
        end
    endtask

    task automatic test_hist_first_frame();
        for (int i = 0; i < 256; i++) frame_m[i] = 16'(i * 3);
        hist_capture(1'b0);
        n_checks++;
        if (shown_m[255] !== 16'd765) begin
            n_errors++; $display("FAIL frame_pattern: model bin255=%0d, want 765", shown_m[255]);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic v; int k, ns = 0, last = -1, gaps = 0, irqs = 0, rb;
        k = $urandom_range(2, 6);
        for (int c = 0; c < 4 * k + 10 && ns < k; c++) begin
            hist_bin_ready = 1'b1; hist_bin_data = 16'($urandom);
            tick();
            if (hist_bin_saved) begin
                if (last >= 0 && c - last != 2) gaps++;
                last = c; ns++;
            end
            if (irq) irqs++;
        end
        hist_bin_ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (ns !== k || gaps !== 0 || irqs !== 0) begin
            n_errors++; $display("FAIL overrun_ack: saved=%0d gaps=%0d irqs=%0d, want %0d 0 0", ns, gaps, irqs, k);
        end
        overrun_m = 1'b1;
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL overrun_status: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
        rb = $urandom_range(0, 255);
        reg_read(10'(256 + rb), d, v);
        n_checks++;
        if (d !== {16'd0, shown_m[rb]}) begin
            n_errors++; $display("FAIL overrun_discard[%0d]: got %h, want %h", rb, d, shown_m[rb]);
        end
        reg_write(10'h001, 32'h8);
        overrun_m = 1'b0;
        reg_read(10'h001, d, v);
        n_checks++;
        if (d !== status_m(1'b0, 1'b0)) begin
            n_errors++; $display("FAIL overrun_clear: got %h, want %h", d, status_m(1'b0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int ns = 0, irqs = 0; logic [15:0] junk;
        reg_write(10'h000, 32'h2);
        hist_valid_m = 1'b0;
        for (int c = 0; c < 60 && ns < 10; c++) begin
            junk = 16'($urandom);
            hist_bin_ready = 1'b1; hist_bin_data = junk;
            tick();
            if (hist_bin_saved) begin
`ifndef HIST_DOUBLE_BUF_EN
                shown_m[ns] = junk;
`endif
                ns++;
            end
            if (irq) irqs++;
        end
        hist_bin_ready = 1'b0;
        n_checks++;
        if (ns !== 10 || irqs !== 0) begin
            n_errors++; $display("FAIL partial_capture: saved=%0d irqs=%0d, want 10 0", ns, irqs);
        end
        for (int i = 0; i < 256; i++) frame_m[i] = 16'($urandom);
        hist_capture(1'b1);
    endtask

    initial begin
        rst = 1'b1; vs_i = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_addr = 10'd0; reg_wdata = 32'd0;
        hist_bin_ready = 1'b0; hist_bin_data = 16'd0;
        test_reset();
        test_regs();
        test_commit_load();
        test_shadow_update();
        test_reset_mid_load();
        test_hist_first_frame();
        test_overrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
